// File: rtl/fifo_uart_tx.sv
// UART-style serial transmitter draining a first-word-fall-through FIFO.
// Frames are start bit, LSB-first data, STOP_BITS stop bits, sent back-to-back while data is available.
module fifo_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_val,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BAUD_W-1:0]     baud_cnt;
   logic                  bit_tick;
   logic                  last_cycle;

   // bit_cnt counts data bits in DATA and stop bits in STOP.
   assign bit_tick   = (baud_cnt == BAUD_LAST);
   assign last_cycle = (state == STOP) && bit_tick && (bit_cnt == STOP_LAST);
   assign rd_en      = rd_val & ((state == IDLE) | last_cycle) & reset;
   assign tx_done    = last_cycle;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         baud_cnt  <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else if (rd_en) begin
         shift_reg <= rd_data;
         state     <= START;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         tx        <= 1'b0;
         busy      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
            end
            START: begin
               if (bit_tick) begin
                  baud_cnt  <= '0;
                  state     <= DATA;
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  if (bit_cnt == DATA_LAST) begin
                     state   <= STOP;
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     tx        <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     busy    <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and randomized bench for fifo_uart_tx against a queue-of-line-bits reference model.
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       rd_val_a, rd_val_b;
   logic [7:0] rd_data_a, rd_data_b;
   logic       rd_en_a, rd_en_b;
   logic       tx_a, tx_b;
   logic       busy_a, busy_b;
   logic       tx_done_a, tx_done_b;

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .rd_val(rd_val_a), .rd_data(rd_data_a),
      .rd_en(rd_en_a), .tx(tx_a), .busy(busy_a), .tx_done(tx_done_a)
   );

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(reset), .rd_val(rd_val_b), .rd_data(rd_data_b),
      .rd_en(rd_en_b), .tx(tx_b), .busy(busy_b), .tx_done(tx_done_b)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         sel     = 0;
   int         cyc     = 0;
   int         pops_seen, dones_seen, last_pop_cyc, last_done_cyc;
   bit         line[$];
   logic [7:0] fifo[$];

   task automatic check(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      logic       v;
      logic [7:0] d;
      v = (fifo.size() != 0);
      d = v ? fifo[0] : 8'h00;
      rd_val_a  = (sel == 0) ? v : 1'b0;
      rd_data_a = (sel == 0) ? d : 8'h00;
      rd_val_b  = (sel == 1) ? v : 1'b0;
      rd_data_b = (sel == 1) ? d : 8'h00;
   endtask

   // Every frame is just a list of line levels, one per clk cycle.
   task automatic push_frame(input logic [7:0] w);
      int cpb, sb;
      cpb = (sel == 0) ? 4 : 3;
      sb  = (sel == 0) ? 1 : 2;
      for (int k = 0; k < cpb; k++) line.push_back(1'b0);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < cpb; k++) line.push_back(w[i]);
      for (int k = 0; k < cpb * sb; k++) line.push_back(1'b1);
   endtask

   task automatic step();
      logic       o_tx, o_busy, o_en, o_done;
      logic       exp_tx, exp_pop;
      logic [7:0] w;
      @(negedge clk);
      o_tx   = (sel == 0) ? tx_a      : tx_b;
      o_busy = (sel == 0) ? busy_a    : busy_b;
      o_en   = (sel == 0) ? rd_en_a   : rd_en_b;
      o_done = (sel == 0) ? tx_done_a : tx_done_b;
      exp_pop = reset && (fifo.size() != 0) && (line.size() <= 1);
      exp_tx  = (line.size() != 0) ? line[0] : 1'b1;
      check("tx", o_tx, exp_tx);
      check("busy", o_busy, line.size() != 0);
      check("rd_en", o_en, exp_pop);
      check("tx_done", o_done, reset && (line.size() == 1));
      if (o_en)   begin pops_seen++;  last_pop_cyc  = cyc; end
      if (o_done) begin dones_seen++; last_done_cyc = cyc; end
      @(posedge clk);
      #1;
      cyc++;
      if (line.size() != 0) void'(line.pop_front());
      if (exp_pop) begin
         w = fifo.pop_front();
         push_frame(w);
      end
      drive_inputs();
   endtask

   task automatic clear_counts();
      pops_seen = 0; dones_seen = 0; last_pop_cyc = -1; last_done_cyc = -1;
   endtask

   initial begin
      reset = 1'b0;
      rd_val_a = 1'b0; rd_val_b = 1'b0; rd_data_a = '0; rd_data_b = '0;
      clear_counts();

      // 1: reset held with data presented
      fifo.push_back(8'h5A);
      drive_inputs();
      for (int i = 0; i < 5; i++) step();
      check_int("reset_pops", pops_seen, 0);
      fifo.delete();
      drive_inputs();
      reset = 1'b1;

      // 2: single word A5
      clear_counts();
      fifo.push_back(8'hA5);
      drive_inputs();
      for (int i = 0; i < 50; i++) step();
      check_int("single_pops", pops_seen, 1);
      check_int("single_dones", dones_seen, 1);
      check_int("single_latency", last_done_cyc - last_pop_cyc, 40);

      // 3: back-to-back 0..3
      clear_counts();
      for (int i = 0; i < 4; i++) fifo.push_back(8'(i));
      drive_inputs();
      for (int i = 0; i < 170; i++) step();
      check_int("b2b_pops", pops_seen, 4);
      check_int("b2b_dones", dones_seen, 4);

      // 4: empty FIFO, then FF
      clear_counts();
      for (int i = 0; i < 50; i++) step();
      check_int("empty_pops", pops_seen, 0);
      fifo.push_back(8'hFF);
      drive_inputs();
      for (int i = 0; i < 45; i++) step();
      check_int("ff_pops", pops_seen, 1);
      check_int("ff_dones", dones_seen, 1);

      // 5: reset on frame cycle 15, then a clean 81 frame
      clear_counts();
      fifo.push_back(8'h3C);
      drive_inputs();
      step();
      for (int i = 0; i < 14; i++) step();
      #2;
      reset = 1'b0;
      #1;
      line.delete();
      check("rst_tx", tx_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", tx_done_a, 1'b0);
      for (int i = 0; i < 3; i++) step();
      check_int("rst_pops", pops_seen, 1);
      check_int("rst_dones", dones_seen, 0);
      reset = 1'b1;
      clear_counts();
      fifo.push_back(8'h81);
      drive_inputs();
      for (int i = 0; i < 45; i++) step();
      check_int("post_rst_pops", pops_seen, 1);
      check_int("post_rst_dones", dones_seen, 1);
      check_int("post_rst_latency", last_done_cyc - last_pop_cyc, 40);

      // Randomized traffic with random gaps, then drain
      clear_counts();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) fifo.push_back(8'($urandom));
            drive_inputs();
         end
         step();
      end
      for (int i = 0; i < 2000; i++) begin
         if (fifo.size() == 0 && line.size() == 0) break;
         step();
      end
      check_int("drain_fifo", fifo.size(), 0);
      check_int("drain_line", line.size(), 0);
      check_int("rand_pops_vs_dones", dones_seen, pops_seen);

      // 6: CLKS_PER_BIT=3, STOP_BITS=2
      sel = 1;
      clear_counts();
      for (int i = 0; i < 3; i++) step();
      fifo.push_back(8'h01);
      drive_inputs();
      for (int i = 0; i < 40; i++) step();
      check_int("sb2_pops", pops_seen, 1);
      check_int("sb2_dones", dones_seen, 1);
      check_int("sb2_latency", last_done_cyc - last_pop_cyc, 33);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Serial transmitter that sits directly downstream of the fifo block and drains it. It pops one DATA_WIDTH word whenever the FIFO reports data available. Each word goes out as a UART-style frame on a single line: start bit, LSB-first data, stop bit(s). Frames run back-to-back with no idle gap while the FIFO stays non-empty.

Parameters:
DATA_WIDTH, 8, width of each FIFO word and data bits per frame
CLKS_PER_BIT, 4, clk cycles per serial bit; minimum 2
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rd_val  input  1  FIFO has data; rd_data holds the head word (first-word-fall-through)
rd_data  input  DATA_WIDTH  head word of FIFO, valid while rd_val=1
rd_en  output  1  pop strobe to FIFO; the word is consumed on the edge where rd_en=1
tx  output  1  serial line, idle high; registered
busy  output  1  1 while a frame is in progress (any state but IDLE); registered
tx_done  output  1  one-cycle pulse on the final clk cycle of the last stop bit

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, busy=0, tx_done=0. Shift register, bit counter and baud counter are cleared. rd_en=0 regardless of rd_val.
- rd_en is combinational: rd_en = rd_val & (state==IDLE | last_cycle_of_frame) & reset.
- Capture: on the edge where rd_en=1, shift_reg <= rd_data, state <= START, baud_cnt <= 0, bit_cnt <= 0. rd_data is sampled only on that edge.
- States:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift_reg[0]; shift right once per bit.
  - STOP: tx=1.
- Bit timing:
  - baud_cnt counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
  - The state/bit advances when baud_cnt==CLKS_PER_BIT-1, and baud_cnt then wraps to 0.
- Transitions:
  - START -> DATA after 1 bit time.
  - DATA -> STOP after DATA_WIDTH bit times (bit_cnt 0..DATA_WIDTH-1).
  - STOP -> IDLE after STOP_BITS bit times, or STOP -> START directly if rd_en=1 in the final cycle.
- Latency: tx falls to 0 on the clk edge that pops the word, i.e. the cycle after rd_en first asserts. Frame length is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_done is asserted exactly during the last cycle of the final stop bit, once per frame, including back-to-back frames.
- busy=1 from the capture edge until the edge leaving STOP to IDLE. busy stays 1 across gapless back-to-back frames.
- Empty FIFO (rd_val=0) in IDLE: hold, tx=1, rd_en=0.
- rd_val during START/DATA/STOP (except the last frame cycle) is ignored, and rd_en=0.
- Mid-frame reset: tx returns to 1 immediately (async). The in-flight word is lost, and no tx_done fires for it. After release, normal operation resumes from IDLE on the next edge.
- tx must be glitch-free: driven from a flop only.

Test Plan:
1. Reset: hold reset=0 with rd_val=1, rd_data=8'h5A for 5 cycles -> tx=1, busy=0, rd_en=0, tx_done=0 throughout.
2. Single word (defaults), rd_val=1 for one pop with rd_data=8'hA5 -> exactly one rd_en pulse. Over 40 cycles tx emits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_done fires once at cycle 40, and busy=0 afterwards.
3. Back-to-back: FIFO preloaded with 0,1,2,3 -> 4 rd_en pulses spaced exactly 40 cycles apart. tx never idles between frames, busy stays 1 for 160 cycles, and the data decodes to 0,1,2,3 with 4 tx_done pulses.
4. Empty FIFO: rd_val=0 for 50 cycles after reset -> state IDLE, tx=1, rd_en=0. Then rd_val=1 with 8'hFF -> frame 0,1×8,1 and one pop.
5. Reset mid-frame: assert reset=0 at cycle 15 of a frame carrying 8'h3C -> tx=1 immediately, busy=0, no tx_done. After release with rd_val=1, 8'h81 -> a complete, correct new frame.
6. STOP_BITS=2, CLKS_PER_BIT=3: send 8'h01 -> frame length 33 cycles, the stop high lasts 6 cycles, and tx_done is on cycle 33.
